// File: rtl/belt_encoder_monitor_if.sv
// belt_encoder_monitor_if: encoder pins, belt command and measurement outputs of the belt encoder monitor
interface belt_encoder_monitor_if #(parameter int CNT_W = 16);
  logic enc_a, enc_b, belt_running, clr_pos;
  logic [CNT_W-1:0] position, speed;
  logic speed_valid, direction, stall, quad_err;
  modport master (output enc_a, enc_b, belt_running, clr_pos,
                  input position, speed, speed_valid, direction, stall, quad_err);
  modport slave (input enc_a, enc_b, belt_running, clr_pos,
                 output position, speed, speed_valid, direction, stall, quad_err);
endinterface

// File: rtl/belt_encoder_monitor.sv
// belt_encoder_monitor: quadrature position/speed tracker with belt stall detection
// ENC_GLITCH_FILTER_EN adds a 4-sample stability filter on each synchronised channel
module belt_encoder_monitor #(
  parameter int CNT_W = 16,
  parameter int GATE_CYCLES = 5000000,
  parameter int MIN_SPEED = 20,
  parameter int STALL_WINDOWS = 3
) (
  input logic clk,
  input logic rst,
  belt_encoder_monitor_if.slave bus
);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int SW = $clog2(STALL_WINDOWS + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0] SLOW_LAST = SW'(STALL_WINDOWS);
  localparam logic [CNT_W-1:0] MIN_SPD = CNT_W'(MIN_SPEED);
  typedef enum logic [1:0] {IDLE, SPINUP, MONITOR, STALLED} state_t;
  logic [1:0] s1_q, s2_q, prev_q, ab;
  logic [CNT_W-1:0] position_q, position_d, speed_q, speed_d, win_q, win_d, win_nx;
  logic [GW-1:0] gate_q, gate_d;
  logic direction_q, direction_d, quad_err_q, quad_err_d, speed_valid_q, speed_valid_d;
  logic fwd, rev, term;
  logic [SW-1:0] slow_q, slow_nx;
  logic stall_q;
  state_t state_q;
`ifdef ENC_GLITCH_FILTER_EN
  logic [1:0] flt_q;
  logic [1:0][1:0] fc_q, fc_d;
  // the 4th consecutive differing sample is passed straight to the decoder
  always_comb begin
    ab = flt_q;
    fc_d = fc_q;
    for (int i = 0; i < 2; i++) begin
      fc_d[i] = (s2_q[i] == flt_q[i] || fc_q[i] == 2'd3) ? 2'd0 : fc_q[i] + 2'd1;
      ab[i] = (s2_q[i] != flt_q[i] && fc_q[i] == 2'd3) ? s2_q[i] : flt_q[i];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      flt_q <= '0;
      fc_q <= '0;
    end else begin
      flt_q <= ab;
      fc_q <= fc_d;
    end
`else
  assign ab = s2_q;
`endif
  // Gray order 00->01->11->10: the forward successor of x is {x[0], ~x[1]}
  always_comb begin
    fwd = ab == {prev_q[0], ~prev_q[1]};
    rev = prev_q == {ab[0], ~ab[1]};
    term = gate_q == GATE_LAST;
    gate_d = term ? '0 : gate_q + GW'(1);
    win_nx = (fwd || rev) && win_q != '1 ? win_q + CNT_W'(1) : win_q;
    win_d = term ? '0 : win_nx;
    speed_d = term ? win_nx : speed_q;
    speed_valid_d = term;
    position_d = bus.clr_pos ? '0 : fwd ? position_q + CNT_W'(1) : rev ? position_q - CNT_W'(1) : position_q;
    direction_d = fwd ? 1'b1 : rev ? 1'b0 : direction_q;
    quad_err_d = !bus.clr_pos && (quad_err_q || (ab ^ prev_q) == 2'b11);
    slow_nx = speed_q < MIN_SPD ? slow_q + SW'(1) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      prev_q <= '0;
      gate_q <= '0;
      win_q <= '0;
      speed_q <= '0;
      speed_valid_q <= 1'b0;
      position_q <= '0;
      direction_q <= 1'b1;
      quad_err_q <= 1'b0;
    end else begin
      s1_q <= {bus.enc_a, bus.enc_b};
      s2_q <= s1_q;
      prev_q <= ab;
      gate_q <= gate_d;
      win_q <= win_d;
      speed_q <= speed_d;
      speed_valid_q <= speed_valid_d;
      position_q <= position_d;
      direction_q <= direction_d;
      quad_err_q <= quad_err_d;
    end
  // belt off overrides any window evaluation
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      slow_q <= '0;
      stall_q <= 1'b0;
    end else if (!bus.belt_running) begin
      state_q <= IDLE;
      slow_q <= '0;
      stall_q <= 1'b0;
    end else
      case (state_q)
        IDLE: state_q <= SPINUP;
        SPINUP: if (speed_valid_q) state_q <= MONITOR;
        MONITOR: if (speed_valid_q) begin
          slow_q <= slow_nx;
          if (slow_nx == SLOW_LAST) begin
            state_q <= STALLED;
            stall_q <= 1'b1;
          end
        end
        default: stall_q <= 1'b1;
      endcase
  assign bus.position = position_q;
  assign bus.speed = speed_q;
  assign bus.speed_valid = speed_valid_q;
  assign bus.direction = direction_q;
  assign bus.stall = stall_q;
  assign bus.quad_err = quad_err_q;
endmodule

// File: tb/tb_belt_encoder_monitor.sv
// tb_belt_encoder_monitor: directed tests of position, speed windows, stall FSM and reset
`timescale 1ns/1ps
module tb_belt_encoder_monitor;
  localparam int CNT_W = 16;
`ifdef ENC_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] ab = 2'b00;
  int checks = 0;
  int errors = 0;
  belt_encoder_monitor_if #(.CNT_W(CNT_W)) bus();
  belt_encoder_monitor #(.CNT_W(CNT_W), .GATE_CYCLES(100), .MIN_SPEED(5), .STALL_WINDOWS(3))
    dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.enc_a = ab[1];
  assign bus.enc_b = ab[0];
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fwd_pins;
    ab = {ab[0], ~ab[1]};
  endtask

  task automatic rev_pins;
    ab = {~ab[0], ab[1]};
  endtask

  task automatic clr_pulse;
    bus.clr_pos = 1'b1;
    tick();
    bus.clr_pos = 1'b0;
  endtask

  task automatic test_reset;
    bus.belt_running = 1'b0;
    bus.clr_pos = 1'b0;
    rst = 1'b1;
    tick(3);
    checks++; if (bus.position !== 16'h0000) begin errors++; $display("FAIL reset_position got %h want 0000", bus.position); end
    checks++; if (bus.speed !== 16'h0000) begin errors++; $display("FAIL reset_speed got %h want 0000", bus.speed); end
    checks++; if (bus.speed_valid !== 1'b0) begin errors++; $display("FAIL reset_speed_valid got %b want 0", bus.speed_valid); end
    checks++; if (bus.direction !== 1'b1) begin errors++; $display("FAIL reset_direction got %b want 1", bus.direction); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    checks++; if (bus.quad_err !== 1'b0) begin errors++; $display("FAIL reset_quad_err got %b want 0", bus.quad_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_forward;
    fwd_pins();
    tick(LAT - 1);
    checks++; if (bus.position !== 16'd0) begin errors++; $display("FAIL latency_early got %h want 0000", bus.position); end
    tick();
    checks++; if (bus.position !== 16'd1) begin errors++; $display("FAIL latency_first_step got %h want 0001", bus.position); end
    tick(4);
    for (int i = 0; i < 9; i++) begin
      fwd_pins();
      tick(4);
    end
    tick(LAT + 1);
    checks++; if (bus.position !== 16'd10) begin errors++; $display("FAIL fwd10_position got %h want 000a", bus.position); end
    checks++; if (bus.direction !== 1'b1) begin errors++; $display("FAIL fwd10_direction got %b want 1", bus.direction); end
  endtask

  task automatic test_reverse;
    clr_pulse();
    checks++; if (bus.position !== 16'd0) begin errors++; $display("FAIL clr_position got %h want 0000", bus.position); end
    for (int i = 0; i < 4; i++) begin
      fwd_pins();
      tick(4);
    end
    for (int i = 0; i < 6; i++) begin
      rev_pins();
      tick(4);
    end
    tick(LAT + 1);
    checks++; if (bus.position !== 16'hfffe) begin errors++; $display("FAIL rev_position got %h want fffe", bus.position); end
    checks++; if (bus.direction !== 1'b0) begin errors++; $display("FAIL rev_direction got %b want 0", bus.direction); end
    checks++; if (bus.quad_err !== 1'b0) begin errors++; $display("FAIL rev_quad_err got %b want 0", bus.quad_err); end
  endtask

  task automatic test_quad_err;
    ab = ~ab;
    tick(LAT + 2);
    checks++; if (bus.quad_err !== 1'b1) begin errors++; $display("FAIL jump_quad_err got %b want 1", bus.quad_err); end
    checks++; if (bus.position !== 16'hfffe) begin errors++; $display("FAIL jump_position got %h want fffe", bus.position); end
    clr_pulse();
    checks++; if (bus.position !== 16'd0) begin errors++; $display("FAIL jump_clr_position got %h want 0000", bus.position); end
    checks++; if (bus.quad_err !== 1'b0) begin errors++; $display("FAIL jump_clr_quad_err got %b want 0", bus.quad_err); end
  endtask

  task automatic test_clr_wins;
    fwd_pins();
    tick(LAT - 1);
    clr_pulse();
    checks++; if (bus.position !== 16'd0) begin errors++; $display("FAIL clr_wins_position got %h want 0000", bus.position); end
    tick(4);
    checks++; if (bus.position !== 16'd0) begin errors++; $display("FAIL clr_wins_later got %h want 0000", bus.position); end
  endtask

  task automatic test_speed;
    int n = 0;
    while (bus.speed_valid !== 1'b1 && n < 150) begin
      tick();
      n++;
    end
    checks++; if (bus.speed_valid !== 1'b1) begin errors++; $display("FAIL speed_valid_timeout got %b want 1", bus.speed_valid); end
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (i == 99 || i == 101 || i == 199) begin
        checks++; if (bus.speed_valid !== 1'b0) begin errors++; $display("FAIL speed_valid_width cycle %0d got %b want 0", i, bus.speed_valid); end
      end
      if (i == 100 || i == 200) begin
        checks++; if (bus.speed_valid !== 1'b1) begin errors++; $display("FAIL speed_valid_pulse cycle %0d got %b want 1", i, bus.speed_valid); end
        checks++; if (bus.speed !== 16'd10) begin errors++; $display("FAIL speed_value cycle %0d got %0d want 10", i, bus.speed); end
      end
      if ((i + LAT) % 10 == 0 && i + LAT <= 200) fwd_pins();
    end
  endtask

  task automatic test_stall;
    int n = 0;
    bus.belt_running = 1'b1;
    tick(250);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL stall_early got %b want 0", bus.stall); end
    while (bus.stall !== 1'b1 && n < 250) begin
      tick();
      n++;
    end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL stall_timeout got %b want 1", bus.stall); end
    checks++; if (bus.speed !== 16'd0) begin errors++; $display("FAIL stall_speed got %0d want 0", bus.speed); end
    bus.belt_running = 1'b0;
    tick();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL stall_release got %b want 0", bus.stall); end
  endtask

  task automatic test_threshold;
    int n = 0;
    bus.belt_running = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (i % 20 == 0) fwd_pins();
      tick();
    end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL min_speed_moving got %b want 0", bus.stall); end
    checks++; if (bus.speed !== 16'd5) begin errors++; $display("FAIL min_speed_value got %0d want 5", bus.speed); end
    while (bus.stall !== 1'b1 && n < 600) begin
      if (n % 25 == 0) fwd_pins();
      tick();
      n++;
    end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL below_min_stall got %b want 1", bus.stall); end
    bus.belt_running = 1'b0;
    tick();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL below_min_release got %b want 0", bus.stall); end
  endtask

  task automatic test_wrap;
    clr_pulse();
    rev_pins();
    tick(LAT + 1);
    checks++; if (bus.position !== 16'hffff) begin errors++; $display("FAIL wrap_under got %h want ffff", bus.position); end
    clr_pulse();
`ifndef ENC_GLITCH_FILTER_EN
    repeat (32767) begin
      fwd_pins();
      tick();
    end
    tick(LAT + 1);
    checks++; if (bus.position !== 16'h7fff) begin errors++; $display("FAIL wrap_max got %h want 7fff", bus.position); end
    fwd_pins();
    tick(LAT + 1);
    checks++; if (bus.position !== 16'h8000) begin errors++; $display("FAIL wrap_over got %h want 8000", bus.position); end
`endif
  endtask

`ifdef ENC_GLITCH_FILTER_EN
  task automatic test_glitch;
    logic [15:0] before;
    before = bus.position;
    ab = ab ^ 2'b10;
    tick(2);
    ab = ab ^ 2'b10;
    tick(LAT + 4);
    checks++; if (bus.position !== before) begin errors++; $display("FAIL glitch_position got %h want %h", bus.position, before); end
    checks++; if (bus.quad_err !== 1'b0) begin errors++; $display("FAIL glitch_quad_err got %b want 0", bus.quad_err); end
  endtask
`endif

  task automatic test_async_reset;
    rev_pins();
    tick(LAT + 1);
    checks++; if (bus.direction !== 1'b0) begin errors++; $display("FAIL pre_reset_direction got %b want 0", bus.direction); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.position !== 16'h0000) begin errors++; $display("FAIL async_position got %h want 0000", bus.position); end
    checks++; if (bus.direction !== 1'b1) begin errors++; $display("FAIL async_direction got %b want 1", bus.direction); end
    checks++; if (bus.speed !== 16'h0000) begin errors++; $display("FAIL async_speed got %h want 0000", bus.speed); end
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_quad_err();
    test_clr_wins();
    test_speed();
    test_stall();
    test_threshold();
    test_wrap();
`ifdef ENC_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
